// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall sequencer: syscall codes, register
// index of $v0, the controller state encoding and the supported-code test.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_READ_INT   = 32'd5;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

    localparam logic [4:0]  V0_REG         = 5'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EMIT      = 3'd1,
        ST_STR_FETCH = 3'd2,
        ST_STR_EMIT  = 3'd3,
        ST_READ_INT  = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_DONE      = 3'd6,
        ST_HALTED    = 3'd7
    } sys_state_e;

    // True for the codes the sequencer executes; anything else is a NOP.
    function automatic logic is_supported(input logic [31:0] code);
        logic ok;
        case (code)
            SYS_PRINT_INT, SYS_PRINT_STR, SYS_READ_INT,
            SYS_EXIT, SYS_PRINT_CHAR: ok = 1'b1;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Picks one byte out of a 32-bit memory word.
//   word          : memory word
//   lane          : byte address bits [1:0]
//   little_endian : 1 = byte 0 in bits 7:0, 0 = byte 0 in bits 31:24
//   lane_byte     : selected byte
module byte_lane_select (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic        little_endian,
    output logic [7:0]  lane_byte
);

    logic [1:0] pos_s;

    // Big-endian storage puts byte 0 in the top lane, so the index is mirrored.
    always_comb begin
        pos_s     = 2'd0;
        lane_byte = 8'd0;
        if (little_endian) begin
            pos_s = lane;
        end else begin
            pos_s = ~lane;
        end
        case (pos_s)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = 8'd0;
        endcase
    end

endmodule

// File: rtl/syscall_sequencer.sv
// Multi-cycle SYSCALL executor for the single-cycle MIPS core.
//   clock, reset        : clock, synchronous active-high reset
//   sys_enable, v0, a0  : SYSCALL decode and its register operands
//   mem_rdata           : memory word at sys_addr (combinational)
//   stall               : hold PC and suppress core register/memory writes
//   sys_mem, sys_addr   : borrow the data-memory address port for strings
//   sys_regwrite/data   : one-cycle write-back into $v0
//   out_*               : console output handshake (char or integer)
//   in_*                : console integer input handshake
//   halted              : exit executed, sticky until reset
module syscall_sequencer #(
    parameter int unsigned MAX_STR_LEN   = 256,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sys_enable,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        sys_mem,
    output logic [31:0] sys_addr,
    output logic        sys_regwrite,
    output logic [31:0] sys_data,
    output logic        out_valid,
    output logic        out_kind,
    output logic [31:0] out_data,
    input  logic        out_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        halted
);

    import syscall_pkg::*;

    sys_state_e  state_r,        state_nxt_s;
    logic [31:0] ptr_r,          ptr_nxt_s;
    logic [31:0] count_r,        count_nxt_s;
    logic        out_valid_r,    out_valid_nxt_s;
    logic        out_kind_r,     out_kind_nxt_s;
    logic [31:0] out_data_r,     out_data_nxt_s;
    logic        sys_mem_r,      sys_mem_nxt_s;
    logic [31:0] sys_addr_r,     sys_addr_nxt_s;
    logic        in_ready_r,     in_ready_nxt_s;
    logic        sys_regwrite_r, sys_regwrite_nxt_s;
    logic [31:0] sys_data_r,     sys_data_nxt_s;
    logic        halted_r,       halted_nxt_s;
    logic        stall_s;
    logic [7:0]  lane_byte_s;
    logic [31:0] ptr_inc_s;
    logic [31:0] count_inc_s;

    assign ptr_inc_s   = ptr_r + 32'd1;
    assign count_inc_s = count_r + 32'd1;

    byte_lane_select u_lane (
        .word          (mem_rdata),
        .lane          (ptr_r[1:0]),
        .little_endian (LITTLE_ENDIAN),
        .lane_byte     (lane_byte_s)
    );

    // Next-state and next-output computation; every output is registered, so
    // the values below are what the outputs show in the following cycle.
    always_comb begin
        state_nxt_s        = state_r;
        ptr_nxt_s          = ptr_r;
        count_nxt_s        = count_r;
        out_valid_nxt_s    = out_valid_r;
        out_kind_nxt_s     = out_kind_r;
        out_data_nxt_s     = out_data_r;
        sys_mem_nxt_s      = 1'b0;
        sys_addr_nxt_s     = 32'd0;
        in_ready_nxt_s     = 1'b0;
        sys_regwrite_nxt_s = 1'b0;
        sys_data_nxt_s     = 32'd0;
        halted_nxt_s       = halted_r;
        case (state_r)
            ST_IDLE: begin
                if (sys_enable) begin
                    case (v0)
                        SYS_PRINT_INT: begin
                            state_nxt_s     = ST_EMIT;
                            out_valid_nxt_s = 1'b1;
                            out_kind_nxt_s  = 1'b1;
                            out_data_nxt_s  = a0;
                        end
                        SYS_PRINT_CHAR: begin
                            state_nxt_s     = ST_EMIT;
                            out_valid_nxt_s = 1'b1;
                            out_kind_nxt_s  = 1'b0;
                            out_data_nxt_s  = {24'd0, a0[7:0]};
                        end
                        SYS_PRINT_STR: begin
                            state_nxt_s    = ST_STR_FETCH;
                            ptr_nxt_s      = a0;
                            count_nxt_s    = 32'd0;
                            sys_mem_nxt_s  = 1'b1;
                            sys_addr_nxt_s = {a0[31:2], 2'b00};
                        end
                        SYS_READ_INT: begin
                            state_nxt_s    = ST_READ_INT;
                            in_ready_nxt_s = 1'b1;
                        end
                        SYS_EXIT: begin
                            state_nxt_s  = ST_HALTED;
                            halted_nxt_s = 1'b1;
                        end
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt_s     = ST_DONE;
                    out_valid_nxt_s = 1'b0;
                    out_kind_nxt_s  = 1'b0;
                    out_data_nxt_s  = 32'd0;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_STR_FETCH: begin
                // The fetched byte is held in out_data until the console takes it.
                if (lane_byte_s == 8'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s     = ST_STR_EMIT;
                    out_valid_nxt_s = 1'b1;
                    out_kind_nxt_s  = 1'b0;
                    out_data_nxt_s  = {24'd0, lane_byte_s};
                end
            end
            ST_STR_EMIT: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    out_data_nxt_s  = 32'd0;
                    ptr_nxt_s       = ptr_inc_s;
                    count_nxt_s     = count_inc_s;
                    if (count_inc_s == MAX_STR_LEN) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s    = ST_STR_FETCH;
                        sys_mem_nxt_s  = 1'b1;
                        sys_addr_nxt_s = {ptr_inc_s[31:2], 2'b00};
                    end
                end else begin
                    state_nxt_s = ST_STR_EMIT;
                end
            end
            ST_READ_INT: begin
                if (in_valid) begin
                    state_nxt_s        = ST_WRITEBACK;
                    sys_regwrite_nxt_s = 1'b1;
                    sys_data_nxt_s     = in_data;
                end else begin
                    state_nxt_s    = ST_READ_INT;
                    in_ready_nxt_s = 1'b1;
                end
            end
            ST_WRITEBACK: state_nxt_s = ST_IDLE;
            // sys_enable is still high here; going straight to IDLE keeps the
            // same SYSCALL from starting again before the PC moves on.
            ST_DONE:      state_nxt_s = ST_IDLE;
            ST_HALTED:    state_nxt_s = ST_HALTED;
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // PC stall: combinational in IDLE so the SYSCALL's own cycle is held.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:      stall_s = sys_enable && is_supported(v0);
                ST_WRITEBACK: stall_s = 1'b0;
                ST_DONE:      stall_s = 1'b0;
                default:      stall_s = 1'b1;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            ptr_r          <= 32'd0;
            count_r        <= 32'd0;
            out_valid_r    <= 1'b0;
            out_kind_r     <= 1'b0;
            out_data_r     <= 32'd0;
            sys_mem_r      <= 1'b0;
            sys_addr_r     <= 32'd0;
            in_ready_r     <= 1'b0;
            sys_regwrite_r <= 1'b0;
            sys_data_r     <= 32'd0;
            halted_r       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            ptr_r          <= ptr_nxt_s;
            count_r        <= count_nxt_s;
            out_valid_r    <= out_valid_nxt_s;
            out_kind_r     <= out_kind_nxt_s;
            out_data_r     <= out_data_nxt_s;
            sys_mem_r      <= sys_mem_nxt_s;
            sys_addr_r     <= sys_addr_nxt_s;
            in_ready_r     <= in_ready_nxt_s;
            sys_regwrite_r <= sys_regwrite_nxt_s;
            sys_data_r     <= sys_data_nxt_s;
            halted_r       <= halted_nxt_s;
        end
    end

    assign stall        = stall_s;
    assign sys_mem      = sys_mem_r;
    assign sys_addr     = sys_addr_r;
    assign sys_regwrite = sys_regwrite_r;
    assign sys_data     = sys_data_r;
    assign out_valid    = out_valid_r;
    assign out_kind     = out_kind_r;
    assign out_data     = out_data_r;
    assign in_ready     = in_ready_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Bench for syscall_sequencer: directed vector table, random syscalls scored
// against a transaction-level model, and hand-written halt/reset sequences.
module tb_syscall_sequencer;

    localparam int MAX = 4;

    logic        clock;
    logic        reset;
    logic        sys_enable;
    logic [31:0] v0;
    logic [31:0] a0;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        sys_mem;
    logic [31:0] sys_addr;
    logic        sys_regwrite;
    logic [31:0] sys_data;
    logic        out_valid;
    logic        out_kind;
    logic [31:0] out_data;
    logic        out_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        halted;

    logic [31:0] mem [0:63];

    syscall_sequencer #(.MAX_STR_LEN(MAX), .LITTLE_ENDIAN(1'b1)) dut (
        .clock(clock), .reset(reset), .sys_enable(sys_enable), .v0(v0), .a0(a0),
        .mem_rdata(mem_rdata), .stall(stall), .sys_mem(sys_mem), .sys_addr(sys_addr),
        .sys_regwrite(sys_regwrite), .sys_data(sys_data), .out_valid(out_valid),
        .out_kind(out_kind), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .halted(halted)
    );

    assign mem_rdata = mem[sys_addr[7:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // observed per syscall
    int          got_stall, got_inrdy, got_unstable, got_idle_bad;
    logic        got_wb, got_done;
    logic [31:0] got_wbdata;
    logic [32:0] got_beats [$];
    logic [31:0] got_fetch [$];

    // expected per syscall (model)
    int          exp_stall, exp_inrdy;
    logic        exp_wb;
    logic [31:0] exp_wbdata;
    logic [32:0] exp_beats [$];
    logic [31:0] exp_fetch [$];

    typedef struct {
        logic [31:0] code;
        logic [31:0] arg;
        int          d;
        int          e;
        logic [31:0] inval;
        int          stall_n;
        int          beats_n;
        logic [32:0] last_beat;
        logic        wb;
        logic [31:0] wb_data;
        int          inrdy_n;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] addr);
        logic [31:0] w;
        w = mem[addr[7:2]];
        return w[8*addr[1:0] +: 8];
    endfunction

    task automatic set_byte(input logic [31:0] addr, input logic [7:0] b);
        logic [31:0] w;
        w = mem[addr[7:2]];
        w[8*addr[1:0] +: 8] = b;
        mem[addr[7:2]] = w;
    endtask

    // Syscall semantics at transaction level: console beats, fetched words,
    // write-back and the number of cycles the PC is held, given that every
    // output beat waits d cycles for ready and read_int waits e cycles.
    task automatic model(input logic [31:0] code, input logic [31:0] a, input int d, input int e,
                         input logic [31:0] inval);
        logic [31:0] addr;
        logic [7:0]  b;
        int          k;
        exp_beats.delete();
        exp_fetch.delete();
        exp_stall  = 0;
        exp_inrdy  = 0;
        exp_wb     = 1'b0;
        exp_wbdata = 32'd0;
        case (code)
            32'd1: begin
                exp_beats.push_back({1'b1, a});
                exp_stall = 1 + d + 1;
            end
            32'd11: begin
                exp_beats.push_back({1'b0, 24'd0, a[7:0]});
                exp_stall = 1 + d + 1;
            end
            32'd4: begin
                exp_stall = 1;
                k = 0;
                for (int n = 0; n < 64; n++) begin
                    addr = a + k;
                    exp_fetch.push_back({addr[31:2], 2'b00});
                    exp_stall++;
                    b = mem_byte(addr);
                    if (b == 8'd0) break;
                    exp_beats.push_back({1'b0, 24'd0, b});
                    exp_stall += d + 1;
                    k++;
                    if (k == MAX) break;
                end
            end
            32'd5: begin
                exp_stall  = e + 2;
                exp_inrdy  = e + 1;
                exp_wb     = 1'b1;
                exp_wbdata = inval;
            end
            default: exp_stall = 0;
        endcase
    endtask

    // Issue one SYSCALL and act as console/memory until the PC advances.
    task automatic run_call(input logic [31:0] code, input logic [31:0] a, input int d, input int e,
                            input logic [31:0] inval);
        int          wait_cnt;
        int          in_cnt;
        logic [32:0] beat_ref;
        got_beats.delete();
        got_fetch.delete();
        got_stall = 0; got_inrdy = 0; got_unstable = 0; got_idle_bad = 0;
        got_wb = 1'b0; got_wbdata = 32'd0; got_done = 1'b0;
        wait_cnt = 0; in_cnt = 0; beat_ref = 33'd0;
        @(posedge clock); #1;
        v0 = code; a0 = a; sys_enable = 1'b1;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clock);
            if (sys_mem) got_fetch.push_back(sys_addr);
            else if (sys_addr != 32'd0) got_idle_bad++;
            if (in_ready) got_inrdy++;
            if (stall) begin
                got_stall++;
                if (out_valid) begin
                    if (wait_cnt == 0) beat_ref = {out_kind, out_data};
                    else if ({out_kind, out_data} != beat_ref) got_unstable++;
                    if (wait_cnt >= d) begin
                        out_ready = 1'b1;
                        got_beats.push_back(beat_ref);
                        wait_cnt = 0;
                    end else begin
                        out_ready = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    out_ready = 1'b0;
                end
                if (in_ready) begin
                    if (in_cnt >= e) begin
                        in_valid = 1'b1;
                        in_data  = inval;
                    end else begin
                        in_valid = 1'b0;
                        in_cnt++;
                    end
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                got_wb     = sys_regwrite;
                got_wbdata = sys_data;
                got_done   = 1'b1;
            end
        end
        chk("completion_timeout", got_done, 1'b1);
        @(posedge clock); #1;
        sys_enable = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("post_idle", {stall, out_valid, in_ready, sys_mem}, 4'd0);
    endtask

    int bad;

    initial begin
        reset = 1'b1; sys_enable = 1'b0; v0 = 32'd0; a0 = 32'd0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h00216948;   // "Hi!" at 0x100
        mem[2]  = 32'h44434241;   // "ABCDEF" at 0x108
        mem[3]  = 32'h00004645;
        mem[63] = 32'h5A000000;   // 'Z' at 0xFFFFFFFF, string wraps to 0x0

        vecs[0]  = '{32'd1,  32'hFFFFFFF6, 0, 0, 32'd0,        2,  1, {1'b1, 32'hFFFFFFF6}, 1'b0, 32'd0,        0};
        vecs[1]  = '{32'd11, 32'h12345641, 3, 0, 32'd0,        5,  1, {1'b0, 32'h41},       1'b0, 32'd0,        0};
        vecs[2]  = '{32'd5,  32'd0,        0, 4, 32'd42,       6,  0, 33'd0,                1'b1, 32'd42,       5};
        vecs[3]  = '{32'd7,  32'h55,       0, 0, 32'd0,        0,  0, 33'd0,                1'b0, 32'd0,        0};
        vecs[4]  = '{32'd4,  32'h101,      0, 0, 32'd0,        6,  2, {1'b0, 32'h21},       1'b0, 32'd0,        0};
        vecs[5]  = '{32'd4,  32'h108,      1, 0, 32'd0,        13, 4, {1'b0, 32'h44},       1'b0, 32'd0,        0};
        vecs[6]  = '{32'd4,  32'h110,      0, 0, 32'd0,        2,  0, 33'd0,                1'b0, 32'd0,        0};
        vecs[7]  = '{32'd5,  32'd0,        0, 0, 32'hDEADBEEF, 2,  0, 33'd0,                1'b1, 32'hDEADBEEF, 1};
        vecs[8]  = '{32'd1,  32'd0,        2, 0, 32'd0,        4,  1, {1'b1, 32'h0},        1'b0, 32'd0,        0};
        vecs[9]  = '{32'd4,  32'h10C,      0, 0, 32'd0,        6,  2, {1'b0, 32'h46},       1'b0, 32'd0,        0};
        vecs[10] = '{32'd4,  32'hFFFFFFFF, 0, 0, 32'd0,        9,  4, {1'b0, 32'h21},       1'b0, 32'd0,        0};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {stall, sys_mem, sys_addr, sys_regwrite, sys_data, out_valid,
                            out_kind, out_data, in_ready, halted}, 128'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 11; i++) begin
            run_call(vecs[i].code, vecs[i].arg, vecs[i].d, vecs[i].e, vecs[i].inval);
            chk($sformatf("vec%0d_stall", i), got_stall, vecs[i].stall_n);
            chk($sformatf("vec%0d_beats", i), got_beats.size(), vecs[i].beats_n);
            if (vecs[i].beats_n > 0 && got_beats.size() > 0)
                chk($sformatf("vec%0d_last_beat", i), got_beats[got_beats.size()-1], vecs[i].last_beat);
            chk($sformatf("vec%0d_regwrite", i), got_wb, vecs[i].wb);
            if (vecs[i].wb) chk($sformatf("vec%0d_wb_data", i), got_wbdata, vecs[i].wb_data);
            chk($sformatf("vec%0d_in_ready", i), got_inrdy, vecs[i].inrdy_n);
            chk($sformatf("vec%0d_hold_stable", i), got_unstable, 0);
            chk($sformatf("vec%0d_addr_idle", i), got_idle_bad, 0);
        end

        // random syscalls against the model
        for (int it = 0; it < 40; it++) begin
            logic [31:0] code, arg, inval;
            int d, e, sel, len;
            sel   = $urandom_range(0, 4);
            arg   = $urandom;
            inval = $urandom;
            d     = $urandom_range(0, 3);
            e     = $urandom_range(0, 5);
            case (sel)
                0:       code = 32'd1;
                1:       code = 32'd11;
                2:       code = 32'd4;
                3:       code = 32'd5;
                default: code = 32'd12 + $urandom_range(0, 1000);
            endcase
            if (code == 32'd4) begin
                for (int i = 0; i < 64; i++) mem[i] = $urandom;
                len = $urandom_range(0, 6);
                for (int j = 0; j < len; j++) set_byte(arg + j, 8'($urandom_range(1, 255)));
                set_byte(arg + len, 8'd0);
            end
            model(code, arg, d, e, inval);
            run_call(code, arg, d, e, inval);
            chk($sformatf("rnd%0d_stall", it), got_stall, exp_stall);
            chk($sformatf("rnd%0d_beats", it), got_beats.size(), exp_beats.size());
            for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
                chk($sformatf("rnd%0d_beat%0d", it, i), got_beats[i], exp_beats[i]);
            chk($sformatf("rnd%0d_fetches", it), got_fetch.size(), exp_fetch.size());
            for (int i = 0; i < exp_fetch.size() && i < got_fetch.size(); i++)
                chk($sformatf("rnd%0d_fetch%0d", it, i), got_fetch[i], exp_fetch[i]);
            chk($sformatf("rnd%0d_regwrite", it), got_wb, exp_wb);
            if (exp_wb) chk($sformatf("rnd%0d_wb_data", it), got_wbdata, exp_wbdata);
            chk($sformatf("rnd%0d_in_ready", it), got_inrdy, exp_inrdy);
            chk($sformatf("rnd%0d_hold_stable", it), got_unstable, 0);
            chk($sformatf("rnd%0d_addr_idle", it), got_idle_bad, 0);
        end

        // exit: stall and halted stick, further syscalls ignored, reset clears
        @(posedge clock); #1;
        v0 = 32'd10; a0 = 32'd0; sys_enable = 1'b1;
        @(negedge clock);
        chk("exit_first_stall", stall, 1'b1);
        @(posedge clock); #1;
        v0 = 32'd1;
        bad = 0;
        repeat (12) begin
            @(negedge clock);
            if (!(stall === 1'b1 && halted === 1'b1 && out_valid === 1'b0)) bad++;
        end
        chk("halted_sticky", bad, 0);
        sys_enable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_clears_halt", {halted, stall}, 2'd0);
        run_call(32'd7, 32'd0, 0, 0, 32'd0);
        chk("nop_after_reset", got_stall, 0);

        // reset while a string character waits for the console
        mem[2] = 32'h44434241;
        mem[3] = 32'h00004645;
        @(posedge clock); #1;
        v0 = 32'd4; a0 = 32'h108; sys_enable = 1'b1; out_ready = 1'b0;
        repeat (4) @(negedge clock);
        chk("str_emit_waiting", {out_valid, out_kind, out_data}, {1'b1, 1'b0, 32'h41});
        @(posedge clock); #1;
        reset = 1'b1; sys_enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("reset_mid_string", {stall, sys_mem, sys_addr, sys_regwrite, sys_data, out_valid,
                                 out_kind, out_data, in_ready, halted}, 128'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_call(32'd11, 32'h5A, 0, 0, 32'd0);
        chk("char_after_abort_stall", got_stall, 2);
        chk("char_after_abort_beats", got_beats.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
